lcd1602_responder: RTL and testbench

Synthesizable HD44780-compatible responder for the LCD1602 port driven by the Z80 glue logic: it samples the `lcd_e`/`lcd_rs`/`lcd_rw` strobes and the data bus, executes the instruction subset used by our firmware, and maintains DDRAM, an address counter and a busy flag. It stands in for the real panel in the CPLD test harness and in simulation. The Z80 can poll it exactly as it polls the real display.

---
 rtl/lcd1602_pkg.sv | 65 ++++++
 rtl/lcd1602_responder_ac_step.sv | 25 ++
 rtl/lcd1602_responder.sv | 190 +++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 responder: instruction codes, DDRAM
// address map, FSM encoding and small address/decode helpers.
package lcd1602_pkg;

    localparam logic [7:0] INS_CLEAR   = 8'h01;
    localparam logic [7:0] INS_HOME    = 8'h02;
    localparam logic [7:0] INS_ENTRY   = 8'h04;
    localparam logic [7:0] INS_DISPLAY = 8'h08;
    localparam logic [7:0] INS_SHIFT   = 8'h10;
    localparam logic [7:0] INS_FUNC    = 8'h20;
    localparam logic [7:0] INS_CGRAM   = 8'h40;
    localparam logic [7:0] INS_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_END  = 7'h67;
    localparam logic [6:0] LINE1_SKIP = 7'h18;

    localparam logic [7:0] SPACE_CODE = 8'h20;
    localparam int         DDRAM_SIZE = 80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_BUSY,
        ST_CLEARING
    } state_e;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_e;

    // The highest set bit selects the instruction; lower bits are its operands.
    function automatic cmd_e decode_ins(input logic [7:0] ins);
        if ((ins & INS_DDRAM) != 8'h00)        return CMD_DDRAM;
        else if ((ins & INS_CGRAM) != 8'h00)   return CMD_CGRAM;
        else if ((ins & INS_FUNC) != 8'h00)    return CMD_FUNC;
        else if ((ins & INS_SHIFT) != 8'h00)   return CMD_SHIFT;
        else if ((ins & INS_DISPLAY) != 8'h00) return CMD_DISPLAY;
        else if ((ins & INS_ENTRY) != 8'h00)   return CMD_ENTRY;
        else if ((ins & INS_HOME) != 8'h00)    return CMD_HOME;
        else if ((ins & INS_CLEAR) != 8'h00)   return CMD_CLEAR;
        else                                   return CMD_NONE;
    endfunction

    function automatic logic [6:0] legal_addr(input logic [6:0] addr);
        if ((addr > LINE0_END && addr < LINE1_BASE) || addr > LINE1_END)
            return LINE0_BASE;
        return addr;
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] addr);
        return (addr < LINE1_BASE) ? addr : addr - LINE1_SKIP;
    endfunction

endpackage

// File: rtl/lcd1602_responder_ac_step.sv
// Next address-counter value for one step up or down, wrapping between the
// two display lines the way the HD44780 does.
module lcd_ac_step
    import lcd1602_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       inc,
    output logic [6:0] ac_next
);

    always_comb begin
        // NOTE: assign a default first so every path drives ac_next and no latch is inferred.
        ac_next = ac;
        if (inc) begin
            if (ac == LINE0_END)      ac_next = LINE1_BASE;
            else if (ac == LINE1_END) ac_next = LINE0_BASE;
            else                      ac_next = ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE)      ac_next = LINE1_END;
            else if (ac == LINE1_BASE) ac_next = LINE0_END;
            else                       ac_next = ac - 7'd1;
        end
    end

endmodule

// File: rtl/lcd1602_responder.sv
// HD44780-compatible bus responder: samples the host strobes, executes the
// firmware's instruction subset and models DDRAM, AC and the busy flag.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int BUSY_CYC  = 37,
    parameter int CLEAR_CYC = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       overrun,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - 1);
    localparam logic [6:0]       CLEAR_LAST = 7'(DDRAM_SIZE - 1);

    logic             e_meta, e_sync, e_prev;
    logic             rise, fall;
    logic             lat_rs, lat_rw;
    logic [7:0]       lat_data;
    logic             exec_rs;
    logic [7:0]       exec_data;
    cmd_e             exec_cmd;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       clr_idx;
    logic [6:0]       ac, ac_next;
    logic             id, step_inc;
    logic             entry_s;
    logic [2:0]       disp_ctl, func_cfg;

    logic [7:0]       mem [DDRAM_SIZE];
    logic             mem_we;
    logic [6:0]       mem_idx, dbg_idx;
    logic [7:0]       mem_wdata, mem_rdata;

    assign rise     = e_sync & ~e_prev;
    assign fall     = ~e_sync & e_prev;
    assign exec_cmd = decode_ins(exec_data);
    // A cursor shift steps by R/L; every other step follows I/D.
    assign step_inc = (state == ST_EXEC && !exec_rs && exec_cmd == CMD_SHIFT) ? exec_data[2] : id;

    lcd_ac_step u_ac_step (
        .ac      (ac),
        .inc     (step_inc),
        .ac_next (ac_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_meta <= 1'b0;
            e_sync <= 1'b0;
            e_prev <= 1'b0;
        end else begin
            e_meta <= lcd_e;
            e_sync <= e_meta;
            e_prev <= e_sync;
        end
    end

    // NOTE: all sequential state uses <= so each flop sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_rs    <= 1'b0;
            lat_rw    <= 1'b0;
            lat_data  <= 8'h00;
            exec_rs   <= 1'b0;
            exec_data <= 8'h00;
            state     <= ST_IDLE;
            cnt       <= '0;
            clr_idx   <= 7'd0;
            ac        <= LINE0_BASE;
            id        <= 1'b1;
            entry_s   <= 1'b0;
            disp_ctl  <= 3'b000;
            func_cfg  <= 3'b000;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
        end else begin
            if (rise) begin
                lat_rs   <= lcd_rs;
                lat_rw   <= lcd_rw;
                lat_data <= data_in;
                data_oe  <= lcd_rw;
                data_out <= lcd_rs ? mem_rdata : {busy, ac};
            end else if (!e_sync) begin
                data_oe <= 1'b0;
            end

            if (fall) begin
                if (lat_rw) begin
                    if (lat_rs) ac <= ac_next;
                end else if (state != ST_IDLE) begin
                    overrun <= 1'b1;
                end else begin
                    state     <= ST_EXEC;
                    exec_rs   <= lat_rs;
                    exec_data <= lat_data;
                end
            end

            case (state)
                ST_EXEC: begin
                    busy  <= 1'b1;
                    state <= ST_BUSY;
                    cnt   <= BUSY_LOAD;
                    if (exec_rs) begin
                        ac <= ac_next;
                    end else begin
                        case (exec_cmd)
                            CMD_CLEAR: begin
                                ac      <= LINE0_BASE;
                                id      <= 1'b1;
                                clr_idx <= 7'd0;
                                cnt     <= CLEAR_LOAD;
                                state   <= ST_CLEARING;
                            end
                            CMD_HOME: begin
                                ac  <= LINE0_BASE;
                                cnt <= CLEAR_LOAD;
                            end
                            CMD_ENTRY: begin
                                id      <= exec_data[1];
                                entry_s <= exec_data[0];
                            end
                            CMD_DISPLAY: disp_ctl <= exec_data[2:0];
                            CMD_SHIFT:   if (!exec_data[3]) ac <= ac_next;
                            CMD_FUNC:    func_cfg <= exec_data[4:2];
                            CMD_DDRAM:   ac <= legal_addr(exec_data[6:0]);
                            default: ;
                        endcase
                    end
                end
                ST_CLEARING: begin
                    clr_idx <= clr_idx + 7'd1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (clr_idx == CLEAR_LAST) begin
                        state <= (cnt == '0) ? ST_IDLE : ST_BUSY;
                        busy  <= (cnt != '0);
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = ddram_index(ac);
        mem_wdata = exec_data;
        if (state == ST_CLEARING) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx;
            mem_wdata = SPACE_CODE;
        end else if (state == ST_EXEC && exec_rs) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: DDRAM has no reset; contents survive rst and are initialised by a clear.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    assign mem_rdata = mem[ddram_index(ac)];
    assign dbg_idx   = ddram_index(dbg_addr);
    assign dbg_data  = (dbg_idx < CLEAR_LAST + 7'd1) ? mem[dbg_idx] : 8'h00;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed self-checking bench for lcd1602_responder: drives host bus cycles
// and compares status, DDRAM and timing against hand-computed values.
module tb_lcd1602_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;
    logic       overrun;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] dbg_data;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_rise_cyc = 0;
    int   busy_fall_cyc = 0;
    int   e_fall_cyc = 0;
    logic busy_q = 1'b0;

    lcd1602_responder #(.BUSY_CYC(37), .CLEAR_CYC(1520)) dut (
        .clk      (clk),
        .rst      (rst),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .busy     (busy),
        .overrun  (overrun),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1 && busy_q !== 1'b1) busy_rise_cyc = cyc;
        if (busy === 1'b0 && busy_q === 1'b1) busy_fall_cyc = cyc;
        busy_q = busy;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One host bus cycle; read data is sampled 3 clk after lcd_e rises.
    task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d,
                             output logic [7:0] rd, output logic oe);
        @(negedge clk);
        lcd_rs  = rs;
        lcd_rw  = rw;
        data_in = d;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        rd = data_out;
        oe = data_oe;
        repeat (5) @(negedge clk);
        lcd_e      = 1'b0;
        e_fall_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        logic [7:0] rd;
        logic       oe;
        bus_cycle(rs, 1'b0, d, rd, oe);
    endtask

    task automatic wait_idle(input int budget, input string what);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", what, busy, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] d);
        bus_write(1'b0, d);
        wait_idle(100, "cmd");
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        logic       oe;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        if (data_out !== 8'h00)   begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        if (data_oe !== 1'b0)     begin errors++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks += 2;
        if (rd !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", rd); end
        if (oe !== 1'b1)  begin errors++; $display("FAIL reset_read_oe: got %b want 1", oe); end
    endtask

    task automatic test_clear;
        logic [7:0] rd;
        logic       oe;
        int         bad = 0;
        bus_write(1'b0, 8'h01);
        checks++;
        if (busy_rise_cyc - e_fall_cyc != 4) begin
            errors++;
            $display("FAIL clear_latency: got %0d want 4", busy_rise_cyc - e_fall_cyc);
        end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h80) begin errors++; $display("FAIL clear_status_busy: got %h want 80", rd); end
        wait_idle(3000, "clear");
        checks++;
        if (busy_fall_cyc - busy_rise_cyc != 1520) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d want 1520", busy_fall_cyc - busy_rise_cyc);
        end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL clear_status_after: got %h want 00", rd); end
        for (int a = 0; a < 128; a++) begin
            if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
                peek(7'(a), rd);
                if (rd !== 8'h20) bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clear_ddram: %0d bytes differ from 20, want 0", bad); end
    endtask

    task automatic test_entry_write;
        logic [7:0] rd;
        logic       oe;
        cmd(8'h06);
        bus_write(1'b1, 8'h41);
        wait_idle(100, "write_a");
        bus_write(1'b1, 8'h42);
        wait_idle(100, "write_b");
        checks++;
        if (busy_fall_cyc - busy_rise_cyc != 37) begin
            errors++;
            $display("FAIL write_busy_len: got %0d want 37", busy_fall_cyc - busy_rise_cyc);
        end
        peek(7'h00, rd);
        checks++;
        if (rd !== 8'h41) begin errors++; $display("FAIL entry_ddram0: got %h want 41", rd); end
        peek(7'h01, rd);
        checks++;
        if (rd !== 8'h42) begin errors++; $display("FAIL entry_ddram1: got %h want 42", rd); end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("FAIL entry_status: got %h want 02", rd); end
    endtask

    task automatic test_line_wrap;
        logic [7:0] rd;
        logic       oe;
        cmd(8'hA7);
        bus_write(1'b1, 8'h55);
        wait_idle(100, "wrap");
        peek(7'h27, rd);
        checks++;
        if (rd !== 8'h55) begin errors++; $display("FAIL wrap_ddram39: got %h want 55", rd); end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h40) begin errors++; $display("FAIL wrap_status: got %h want 40", rd); end
    endtask

    task automatic test_decrement;
        logic [7:0] rd;
        logic       oe;
        cmd(8'h04);
        cmd(8'h80);
        bus_write(1'b1, 8'h33);
        wait_idle(100, "dec");
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h67) begin errors++; $display("FAIL dec_status: got %h want 67", rd); end
        peek(7'h00, rd);
        checks++;
        if (rd !== 8'h33) begin errors++; $display("FAIL dec_ddram0: got %h want 33", rd); end
    endtask

    task automatic test_illegal_addr;
        logic [7:0] rd;
        logic       oe;
        cmd(8'h85);
        cmd(8'hB0);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL illegal_30: got %h want 00", rd); end
        cmd(8'h85);
        cmd(8'hE8);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL illegal_68: got %h want 00", rd); end
    endtask

    task automatic test_shift;
        logic [7:0] rd;
        logic       oe;
        cmd(8'hA7);
        cmd(8'h14);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h40) begin errors++; $display("FAIL shift_right: got %h want 40", rd); end
        cmd(8'h1C);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h40) begin errors++; $display("FAIL shift_display_noop: got %h want 40", rd); end
        cmd(8'h10);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h27) begin errors++; $display("FAIL shift_left: got %h want 27", rd); end
    endtask

    task automatic test_overrun;
        logic [7:0] rd;
        logic       oe;
        cmd(8'h06);
        cmd(8'h85);
        bus_write(1'b1, 8'h77);
        bus_write(1'b1, 8'h99);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        wait_idle(100, "overrun");
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h06) begin errors++; $display("FAIL overrun_status: got %h want 06", rd); end
        peek(7'h05, rd);
        checks++;
        if (rd !== 8'h77) begin errors++; $display("FAIL overrun_ddram5: got %h want 77", rd); end
        peek(7'h06, rd);
        checks++;
        if (rd !== 8'h20) begin errors++; $display("FAIL overrun_ddram6: got %h want 20", rd); end
    endtask

    task automatic test_read_data;
        logic [7:0] rd;
        logic       oe;
        cmd(8'hC0);
        bus_cycle(1'b1, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h20) begin errors++; $display("FAIL read_inc_data: got %h want 20", rd); end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h41) begin errors++; $display("FAIL read_inc_status: got %h want 41", rd); end
        cmd(8'h04);
        cmd(8'hC0);
        bus_cycle(1'b1, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h20) begin errors++; $display("FAIL read_dec_data: got %h want 20", rd); end
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h27) begin errors++; $display("FAIL read_dec_status: got %h want 27", rd); end
    endtask

    task automatic test_reset_mid_busy;
        logic [7:0] rd;
        logic       oe;
        cmd(8'h06);
        cmd(8'h8A);
        bus_write(1'b1, 8'h66);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (overrun !== 1'b0)   begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out: got %h want 00", data_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_cycle(1'b0, 1'b1, 8'h00, rd, oe);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL midrst_status: got %h want 00", rd); end
        peek(7'h0A, rd);
        checks++;
        if (rd !== 8'h66) begin errors++; $display("FAIL midrst_ddram10: got %h want 66", rd); end
        peek(7'h00, rd);
        checks++;
        if (rd !== 8'h33) begin errors++; $display("FAIL midrst_ddram0: got %h want 33", rd); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_entry_write();
        test_line_wrap();
        test_decrement();
        test_illegal_addr();
        test_shift();
        test_overrun();
        test_read_data();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
